// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: valid/ready word capture, one bit per clock with a frame strobe.
// Optional even-parity trailer cycle when PISO_SERIALIZER_PARITY_EN is defined.
module piso_serializer #(
  parameter int unsigned width     = 8,
  parameter bit          lsb_first = 1'b0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [width-1:0] data_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             data_out,
  output logic             frame_out,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(width);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(width - 1);

`ifdef PISO_SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [width-1:0] shreg_q, shreg_d;
  logic             data_out_d, frame_out_d;
  logic             accept;
  logic             load, go_idle;
  logic             first_bit, next_bit;
  logic [width-1:0] load_val, shift_val;
`ifdef PISO_SERIALIZER_PARITY_EN
  logic             par_q, par_d;
`endif

  // The first bit goes straight to data_out on accept; the register holds the remaining bits.
  assign first_bit = lsb_first ? data_in[0] : data_in[width-1];
  assign load_val  = lsb_first ? (data_in >> 1) : (data_in << 1);
  assign next_bit  = lsb_first ? shreg_q[0] : shreg_q[width-1];
  assign shift_val = lsb_first ? (shreg_q >> 1) : (shreg_q << 1);

  assign accept = in_valid && in_ready;
  assign busy   = (state_q != IDLE);

  always_comb begin
    in_ready = 1'b0;
    if (reset_n) begin
      case (state_q)
        IDLE:   in_ready = 1'b1;
`ifdef PISO_SERIALIZER_PARITY_EN
        PARITY: in_ready = 1'b1;
        default: in_ready = 1'b0;
`else
        SHIFT:  in_ready = (cnt_q == LAST);
        default: in_ready = 1'b0;
`endif
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    data_out_d  = data_out;
    frame_out_d = frame_out;
    load        = 1'b0;
    go_idle     = 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
    par_d       = par_q;
`endif
    case (state_q)
      IDLE: load = accept;
      SHIFT: begin
        if (cnt_q != LAST) begin
          cnt_d      = cnt_q + 1'b1;
          shreg_d    = shift_val;
          data_out_d = next_bit;
        end else begin
`ifdef PISO_SERIALIZER_PARITY_EN
          state_d    = PARITY;
          data_out_d = par_q;
`else
          load    = accept;
          go_idle = !accept;
`endif
        end
      end
`ifdef PISO_SERIALIZER_PARITY_EN
      PARITY: begin
        load    = accept;
        go_idle = !accept;
      end
`endif
      default: go_idle = 1'b1;
    endcase

    if (load) begin
      state_d     = SHIFT;
      cnt_d       = '0;
      shreg_d     = load_val;
      data_out_d  = first_bit;
      frame_out_d = 1'b1;
`ifdef PISO_SERIALIZER_PARITY_EN
      par_d       = ^data_in;
`endif
    end else if (go_idle) begin
      state_d     = IDLE;
      cnt_d       = '0;
      data_out_d  = 1'b0;
      frame_out_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shreg_q   <= '0;
      data_out  <= 1'b0;
      frame_out <= 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      data_out  <= data_out_d;
      frame_out <= frame_out_d;
`ifdef PISO_SERIALIZER_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer (width=4): MSB-first and LSB-first instances against a bit-queue model.
// Honours PISO_SERIALIZER_PARITY_EN in both the model and the literal expectations.
module tb_piso_serializer;

  localparam int unsigned W = 4;
`ifdef PISO_SERIALIZER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         in_valid = 1'b0;
  logic         in_ready0, data_out0, frame_out0, busy0;
  logic         in_ready1, data_out1, frame_out1, busy1;

  int n_cmp = 0;
  int n_bad = 0;

  piso_serializer #(.width(W), .lsb_first(1'b0)) dut (
    .clock(clock), .reset_n(reset_n), .data_in(data_in), .in_valid(in_valid),
    .in_ready(in_ready0), .data_out(data_out0), .frame_out(frame_out0), .busy(busy0)
  );

  piso_serializer #(.width(W), .lsb_first(1'b1)) dut_l (
    .clock(clock), .reset_n(reset_n), .data_in(data_in), .in_valid(in_valid),
    .in_ready(in_ready1), .data_out(data_out1), .frame_out(frame_out1), .busy(busy1)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: queue of bits still to appear; front is what data_out shows now.
  bit qm[$];
  bit ql[$];

  always @(posedge clock or negedge reset_n) begin
    bit acc;
    if (!reset_n) begin
      qm.delete();
      ql.delete();
    end else begin
      acc = in_valid && (qm.size() <= 1);
      if (qm.size() > 0) void'(qm.pop_front());
      if (ql.size() > 0) void'(ql.pop_front());
      if (acc) begin
        for (int i = 0; i < W; i++) begin
          qm.push_back(data_in[W-1-i]);
          ql.push_back(data_in[i]);
        end
        if (PAR) begin
          qm.push_back(^data_in);
          ql.push_back(^data_in);
        end
      end
    end
  end

  // Framed bits as seen on each instance, first bit ends up most significant.
  logic [31:0] log0, log1;
  int          n0, n1;

  always @(negedge clock) begin
    logic rdy;
    rdy = reset_n && (qm.size() <= 1);
    chk("ready_m", in_ready0, rdy);
    chk("data_m",  data_out0, (qm.size() > 0) ? qm[0] : 1'b0);
    chk("frame_m", frame_out0, qm.size() > 0);
    chk("busy_m",  busy0, qm.size() > 0);
    chk("ready_l", in_ready1, rdy);
    chk("data_l",  data_out1, (ql.size() > 0) ? ql[0] : 1'b0);
    chk("frame_l", frame_out1, ql.size() > 0);
    chk("busy_l",  busy1, ql.size() > 0);
    if (frame_out0) begin log0 = {log0[30:0], data_out0}; n0++; end
    if (frame_out1) begin log1 = {log1[30:0], data_out1}; n1++; end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic clear_logs();
    log0 = '0; log1 = '0; n0 = 0; n1 = 0;
  endtask

  // Present a word and hold it until an edge accepts it; leaves in_valid high.
  task automatic send(input logic [W-1:0] w);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    data_in  = w;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clock);
      done = in_ready0;
      tick();
    end
    if (!done) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    in_valid = 1'b0;
    for (int c = 0; c < 64 && busy0; c++) tick();
    chk("idle_timeout", busy0, 0);
    tick();
  endtask

  task automatic chk_log(input string name, input int len, input logic [31:0] exp_m,
                         input logic [31:0] exp_l);
    chk({name, "_len"}, n0, len);
    chk({name, "_msb"}, log0, exp_m);
    chk({name, "_lsb"}, log1, exp_l);
  endtask

  initial begin
    bit rdy;
    clear_logs();
    // Reset held with a valid word presented.
    reset_n = 1'b0; in_valid = 1'b1; data_in = 4'b1011;
    repeat (2) tick();
    #1;
    chk("rst_ready", in_ready0, 0);
    chk("rst_data",  data_out0, 0);
    chk("rst_frame", frame_out0, 0);
    chk("rst_busy",  busy0, 0);
    in_valid = 1'b0;
    reset_n = 1'b1;
    #1;
    chk("rel_ready", in_ready0, 1);
    tick();

    // Single word 1011 (parity 1).
    clear_logs();
    send(4'b1011);
    wait_idle();
    #1;
    if (PAR) chk_log("single", 5, 32'b10111, 32'b11011);
    else     chk_log("single", 4, 32'b1011,  32'b1101);
    chk("single_frame", frame_out0, 0);
    chk("single_busy",  busy0, 0);
    chk("single_ready", in_ready0, 1);
    tick();

    // Back-to-back 1100 then 0011 with valid held.
    clear_logs();
    send(4'b1100);
    send(4'b0011);
    wait_idle();
    if (PAR) chk_log("b2b", 10, 32'b1100000110, 32'b0011011000);
    else     chk_log("b2b", 8,  32'b11000011,   32'b00111100);

    // Backpressure: 1111 offered during the second bit of 1010.
    clear_logs();
    send(4'b1010);
    in_valid = 1'b0;
    tick();
    send(4'b1111);
    wait_idle();
    if (PAR) chk_log("bp", 10, 32'b1010011110, 32'b0101011110);
    else     chk_log("bp", 8,  32'b10101111,   32'b01011111);

    // 0001: LSB-first instance leads with the set bit.
    clear_logs();
    send(4'b0001);
    wait_idle();
    if (PAR) chk_log("lsb", 5, 32'b00011, 32'b10001);
    else     chk_log("lsb", 4, 32'b0001,  32'b1000);

    // 0111 (parity 1).
    clear_logs();
    send(4'b0111);
    wait_idle();
    if (PAR) chk_log("par", 5, 32'b01111, 32'b11101);
    else     chk_log("par", 4, 32'b0111,  32'b1110);

    // Reset while bit 2 of 1111 is on the line.
    clear_logs();
    send(4'b1111);
    in_valid = 1'b0;
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    chk("mid_rst_frame", frame_out0, 0);
    chk("mid_rst_data",  data_out0, 0);
    chk("mid_rst_busy",  busy0, 0);
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (8) tick();
    chk("mid_rst_len",  n0, 2);
    chk("mid_rst_bits", log0, 32'b11);

    // Randomized traffic with occasional resets; the source holds each word until taken.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      rdy = in_ready0;
      tick();
      if (!reset_n) reset_n = 1'b1;
      else if ($urandom_range(0, 199) == 0) reset_n = 1'b0;
      if (in_valid && rdy) in_valid = 1'b0;
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        data_in  = W'($urandom);
      end
    end
    in_valid = 1'b0;
    repeat (12) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
